// File: rtl/mm_iddmm_ctrl.sv
// mm_iddmm_ctrl: IDDMM Montgomery controller with run-time m/m1/rou; MM_IDDMM_CTRL_PERF_CNT_EN adds perf_cycles
module mm_iddmm_ctrl #(
  parameter int K = 128,
  parameter int N = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr_en,
  input  logic [1:0]        cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [K-1:0]      cfg_data,
  input  logic              op_start,
  input  logic              op_mode,
  output logic              busy,
`ifdef MM_IDDMM_CTRL_PERF_CNT_EN
  output logic [31:0]       perf_cycles,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_x,
  input  logic [K-1:0]      in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic [2:0]        eng_wr_ena,
  output logic [ADDR_W-1:0] eng_wr_addr,
  output logic [K-1:0]      eng_wr_x,
  output logic [K-1:0]      eng_wr_y,
  output logic [K-1:0]      eng_wr_m,
  output logic [K-1:0]      eng_wr_m1,
  output logic              eng_task_req,
  input  logic              eng_task_end,
  input  logic              eng_task_grant,
  input  logic [K-1:0]      eng_task_res
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, REQ, OUT} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0] N_W = (ADDR_W + 1)'(N);
  state_t state, state_n;
  logic mode;
  logic [1:0] pass;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0] g;
  logic [K-1:0] m_r [N];
  logic [K-1:0] rou_r [N];
  logic [K-1:0] x_r [N];
  logic [K-1:0] y_r [N];
  logic [K-1:0] a_r [N];
  logic [K-1:0] b_r [N];
  logic [K-1:0] res_r [N];
  logic [K-1:0] m1_r;
  logic [K-1:0] wx, wy, one;
  logic cnt_last, final_pass, adv, g_ok;
  assign cnt_last = cnt == LAST;
  assign final_pass = !mode || pass == 2'd3;
  assign adv = (state == LOAD && in_valid) || state == WRITE || (state == OUT && out_ready);
  assign g_ok = eng_task_grant && g < N_W;
  assign one = K'(cnt == '0);
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign out_valid = state == OUT;
  assign out_last = out_valid && cnt_last;
  assign out_data = out_valid ? res_r[cnt] : '0;
  assign eng_wr_m1 = m1_r;
  // next state
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (op_start) state_n = LOAD;
      LOAD:    if (in_valid && cnt_last) state_n = WRITE;
      WRITE:   if (cnt_last) state_n = REQ;
      REQ:     if (eng_task_end) state_n = final_pass ? OUT : WRITE;
      OUT:     if (out_ready && cnt_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // operand selection per pass: FULL chains (x,rou)->A, (y,rou)->B, (A,B)->A, (A,1)->result
  always_comb begin
    wx = (mode && pass == 2'd1) ? y_r[cnt] : (mode && pass[1]) ? a_r[cnt] : x_r[cnt];
    wy = !mode ? y_r[cnt] : pass == 2'd2 ? b_r[cnt] : pass == 2'd3 ? one : rou_r[cnt];
  end
  // state, word counters and pass tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode <= 1'b0;
      pass <= 2'd0;
      cnt <= '0;
      g <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + ADDR_W'(adv);
      g <= state != REQ ? '0 : g_ok ? g + (ADDR_W + 1)'(1) : g;
      if (state == IDLE && op_start) begin
        mode <= op_mode;
        pass <= 2'd0;
      end else if (state == REQ && eng_task_end && !final_pass) begin
        pass <= pass + 2'd1;
      end
    end
  end
  // configuration, operand and result storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_r <= '0;
      for (int i = 0; i < N; i++) begin
        m_r[i] <= '0;
        rou_r[i] <= '0;
        x_r[i] <= '0;
        y_r[i] <= '0;
        a_r[i] <= '0;
        b_r[i] <= '0;
        res_r[i] <= '0;
      end
    end else begin
      if (state == IDLE && cfg_wr_en) begin
        if (cfg_sel == 2'd0) m_r[cfg_addr] <= cfg_data;
        if (cfg_sel == 2'd1) rou_r[cfg_addr] <= cfg_data;
        if (cfg_sel == 2'd2) m1_r <= cfg_data;
      end
      if (state == LOAD && in_valid) begin
        x_r[cnt] <= in_x;
        y_r[cnt] <= in_y;
      end
      if (state == REQ && g_ok) begin
        if (final_pass) res_r[g[ADDR_W-1:0]] <= eng_task_res;
        else if (pass == 2'd1) b_r[g[ADDR_W-1:0]] <= eng_task_res;
        else a_r[g[ADDR_W-1:0]] <= eng_task_res;
      end
    end
  end
  // registered engine write port and task request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_wr_ena <= 3'b000;
      eng_wr_addr <= '0;
      eng_wr_x <= '0;
      eng_wr_y <= '0;
      eng_wr_m <= '0;
      eng_task_req <= 1'b0;
    end else begin
      eng_wr_ena <= state == WRITE ? 3'b111 : 3'b000;
      eng_task_req <= state == REQ && !eng_task_end;
      if (state == WRITE) begin
        eng_wr_addr <= cnt;
        eng_wr_x <= wx;
        eng_wr_y <= wy;
        eng_wr_m <= m_r[cnt];
      end
    end
  end
`ifdef MM_IDDMM_CTRL_PERF_CNT_EN
  // saturating busy-cycle counter, cleared on accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cycles <= '0;
    else if (state == IDLE && op_start) perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule

// File: doc/mm_iddmm_ctrl.md
Name: mm_iddmm_ctrl

Overview:
Parametrised successor controller for the IDDMM Montgomery engine (mmp_iddmm_sp). Modulus m, m1 and rou (2^(2*K*N) mod m) are run-time loadable, not compiled in. Two modes: single Montgomery product x*y*R^-1 mod m (1 pass), or full modular product x*y mod m (4 passes). Exposes the engine write/task interface as ports so the engine is instantiated alongside; results leave through an output buffer with valid/ready backpressure.

Parameters:
K, 128, bits per word
N, 16, words per operand (N>=2)
ADDR_W, $clog2(N), word address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_wr_en  in  1  config word write strobe
cfg_sel  in  2  0=m word, 1=rou word, 2=m1 (cfg_addr ignored), 3=reserved (dropped)
cfg_addr  in  ADDR_W  config word index
cfg_data  in  K  config word
op_start  in  1  start pulse, sampled in IDLE only
op_mode  in  1  0=MONT (x*y*R^-1), 1=FULL (x*y mod m); latched at op_start
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand word valid
in_ready  out  1  high in LOAD only
in_x  in  K  x word, low word first
in_y  in  K  y word, low word first
out_valid  out  1  result word valid
out_ready  in  1  result word accepted
out_data  out  K  result word, low word first
out_last  out  1  high with word N-1
eng_wr_ena  out  3  {m,y,x} write enables to engine
eng_wr_addr  out  ADDR_W  engine word address
eng_wr_x  out  K  engine x word
eng_wr_y  out  K  engine y word
eng_wr_m  out  K  engine m word
eng_wr_m1  out  K  m1 register, continuous
eng_task_req  out  1  engine task request
eng_task_end  in  1  engine pass complete
eng_task_grant  in  1  engine result word valid
eng_task_res  in  K  engine result word

Behaviour:
- Reset: all outputs 0, state IDLE, m/rou/m1 registers and x/y/A/B/result buffers cleared.
- Config writes honoured only in IDLE; while busy dropped silently (register unchanged).
- States: IDLE -> LOAD -> WRITE -> REQ -> (WRITE next pass | OUT) -> IDLE.
- IDLE: op_start=1 latches op_mode, pass=0, goes LOAD next cycle. op_start when busy ignored.
- LOAD: in_ready=1; each in_valid&in_ready stores in_x/in_y at word cnt, cnt++; after word N-1 -> WRITE. No timeout.
- WRITE: N cycles, word k at cycle k: eng_wr_ena=3'b111, eng_wr_addr=k, eng_wr_m=m[k]; all registered outputs; eng_wr_ena=0 outside WRITE.
- Pass operands: MONT pass0 (x,y). FULL pass0 (x,rou)->A; pass1 (y,rou)->B; pass2 (A,B)->C (C overwrites A); pass3 (C, one) where one word0=1, others 0.
- REQ: eng_task_req=1 from the cycle after last write until the cycle after eng_task_end sampled high. Each eng_task_grant stores eng_task_res at grant index g, g++; grants beyond N ignored. eng_task_end with grant in same cycle: word stored, then leave.
- After final pass (MONT pass0, FULL pass3) -> OUT, else pass++ -> WRITE.
- OUT: out_valid=1, out_data=result[j]; j advances on out_valid&out_ready; out_last=(j==N-1); after last handshake -> IDLE, busy falls next cycle. Data stable while out_ready=0.
- Latency MONT: N load + N write + engine + N out cycles minimum.
- Reset mid-operation: immediate return to IDLE, eng_task_req and eng_wr_ena drop asynchronously; config lost.

Optional Feature:
MM_IDDMM_CTRL_PERF_CNT_EN: adds output perf_cycles[31:0]: counter cleared at op_start, increments each busy cycle, saturates at 0xFFFFFFFF, holds after return to IDLE, reset 0. Without macro: port and counter absent, behaviour otherwise identical.

Test Plan:
- K=8,N=2; cfg m={0x0D,0xF1}, m1=0x3B; MONT, x={0x11,0x22}, y={0x33,0x44} -> engine sees addr0 x=0x11 y=0x33 m=0x0D, addr1 x=0x22 y=0x44 m=0xF1; one pass; output = engine-model words, out_last on word1.
- Same config plus rou={0xA0,0xA1}; FULL -> 4 passes, pass3 wr_y={0x01,0x00}; output equals (x*y) mod m from reference model.
- FULL with out_ready held 0 for 20 cycles after out_valid -> out_data stable, no word lost, 2 handshakes total.
- cfg_wr_en sel=0 addr0 data=0xFF while busy -> m[0] stays 0x0D; op_start while busy ignored.
- rst_n low during REQ of pass1 -> eng_task_req=0, busy=0 immediately; new MONT op after reload completes correctly.
- PERF_CNT_EN: MONT op with engine model latency 10 -> perf_cycles equals busy cycle count, frozen in IDLE.
